// File: rtl/contador_mod_n.sv
// Modulo-N up/down counter: clear, load with clamp, wrap or saturate, tc pulse.
// Optional prescaler on the count enable when CONTADOR_PRESC_EN is defined.
module contador_mod_n #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter bit              SATURATE = 1'b0
`ifdef CONTADOR_PRESC_EN
  ,
  parameter int unsigned     PRESC    = 4
`endif
) (
  input  logic             clk_reloj,
  input  logic             rst_reset,
  input  logic             clr,
  input  logic             ld_load,
  input  logic [WIDTH-1:0] d_dato,
  input  logic             en_enable,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc_pulse,
`ifdef CONTADOR_PRESC_EN
  output logic             sat,
  output logic             presc_tick
`else
  output logic             sat
`endif
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "contador_mod_n: WIDTH out of range");
  end
  if (MODULO < 64'd2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_mod
    $fatal(1, "contador_mod_n: MODULO out of range");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             step;

`ifdef CONTADOR_PRESC_EN
  if (PRESC < 2) begin : g_bad_presc
    $fatal(1, "contador_mod_n: PRESC must be >= 2");
  end

  localparam int unsigned PW = $clog2(PRESC);
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Prescaler restarts on clear/load; q steps on its last phase.
  always_comb begin
    presc_d = presc_q;
    step    = 1'b0;
    if (clr || ld_load) begin
      presc_d = '0;
    end else if (en_enable) begin
      if (presc_q == PLAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_reloj or negedge rst_reset) begin
    if (!rst_reset) presc_q <= '0;
    else            presc_q <= presc_d;
  end

  assign presc_tick = step;
`else
  assign step = en_enable && !clr && !ld_load;
`endif

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    sat_d = sat_q;
    if (clr) begin
      q_d   = '0;
      sat_d = 1'b0;
    end else if (ld_load) begin
      q_d   = (d_dato > MAX) ? MAX : d_dato;
      sat_d = 1'b0;
    end else if (step) begin
      if (up_dn) begin
        if (q_q != MAX) begin
          q_d   = q_q + ONE;
          sat_d = 1'b0;
        end else if (SATURATE) begin
          sat_d = 1'b1;
          tc_d  = !sat_q;
        end else begin
          q_d  = '0;
          tc_d = 1'b1;
        end
      end else begin
        if (q_q != '0) begin
          q_d   = q_q - ONE;
          sat_d = 1'b0;
        end else if (SATURATE) begin
          sat_d = 1'b1;
          tc_d  = !sat_q;
        end else begin
          q_d  = MAX;
          tc_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_reloj or negedge rst_reset) begin
    if (!rst_reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      sat_q <= sat_d;
    end
  end

  assign q        = q_q;
  assign tc_pulse = tc_q;
  assign sat      = sat_q;

endmodule

// File: doc/contador_mod_n.md
Name: contador_mod_n

Overview:
- Parametrised modulo-N up/down counter. Generalises the fixed 2-bit free-running counter.
- Adds: configurable width and modulus, enable, direction, synchronous clear and load, wrap or saturate mode, registered terminal-count pulse.
- Used as the generic time base, digit scanner and event counter in display/timing paths.
- Single clock domain.

Parameters:
- WIDTH, 4, counter register width in bits; legal range 1..32.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2^WIDTH.
- SATURATE, 0, 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk_reloj  input  1  system clock; all state changes on the rising edge.
- rst_reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- clr  input  1  synchronous clear to 0; highest priority after reset.
- ld_load  input  1  synchronous load of d_dato.
- d_dato  input  WIDTH  load value.
- en_enable  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- q  output  WIDTH  counter value, registered.
- tc_pulse  output  1  one-cycle registered pulse when the counter crosses a bound.
- sat  output  1  level; high while held at a bound in saturate mode.

Behaviour:
- Reset (rst_reset=0, async): q=0, tc_pulse=0, sat=0; held until the first rising edge after rst_reset returns to 1. Reset asserted mid-count aborts immediately; no pulse is generated.
- Priority per edge: clr > ld_load > en_enable. Idle (none asserted): q holds, tc_pulse=0, sat unchanged.
- clr=1: q<=0, tc_pulse<=0, sat<=0.
- ld_load=1:
  - q<=d_dato if d_dato<MODULO, else q<=MODULO-1 (clamp).
  - tc_pulse<=0, sat<=0.
  - Load overrides en_enable in the same cycle.
- Count up (en_enable=1, up_dn=1):
  - q<MODULO-1: q<=q+1, tc_pulse<=0, sat<=0.
  - q==MODULO-1, SATURATE=0: q<=0, tc_pulse<=1.
  - q==MODULO-1, SATURATE=1: q holds, sat<=1, tc_pulse<=1 only on the first saturating cycle (sat was 0), else 0.
- Count down (en_enable=1, up_dn=0):
  - q>0: q<=q-1, sat<=0.
  - q==0, SATURATE=0: q<=MODULO-1, tc_pulse<=1.
  - q==0, SATURATE=1: hold, sat<=1, first-cycle tc_pulse as for count up.
- Direction reversal while saturated: moves off the bound on the next enabled edge and clears sat.
- Latency: q and tc_pulse update one clock after the qualifying edge; tc_pulse is high in the same cycle q shows the wrapped value.
- Arithmetic is WIDTH-bit. When MODULO=2^WIDTH, the natural overflow equals the wrap (no extra compare logic required, but same visible behaviour).
- Elaboration check: MODULO outside 2..2^WIDTH is a fatal error.

Optional Feature:
- Macro: CONTADOR_PRESC_EN.
- When defined:
  - Adds parameter PRESC (default 4, legal range ≥2) and an internal prescaler counter.
  - en_enable advances the prescaler; q steps only on every PRESC-th enabled cycle.
  - The prescaler resets to 0 on rst_reset, clr and ld_load.
  - Adds output presc_tick (1 bit), high for the cycle in which q steps.
- When undefined: no prescaler, no presc_tick port; q steps on every enabled cycle.

Test Plan:
- Reset: drive rst_reset=0 mid-count at q=7, asynchronously between edges -> q=0, tc_pulse=0, sat=0 before the next edge; after release, counting restarts from 0.
- Wrap up, WIDTH=4, MODULO=10: en_enable=1, up_dn=1 for 12 cycles -> q = 1..9, 0, 1, 2; tc_pulse high only in the cycle q=0.
- Wrap down, MODULO=10: load 1, then count down 3 cycles -> q = 0, 9, 8; tc_pulse high with q=9.
- Saturate, SATURATE=1, MODULO=10: count up from 8 for 4 cycles -> q = 9, 9, 9, 9; sat=1 from the second cycle; tc_pulse high once. Then up_dn=0 -> q=8, sat=0.
- Priority/clamp: clr=1, ld_load=1, en_enable=1 in one cycle -> q=0. Then ld_load=1 with d_dato=13, MODULO=10 -> q=9. Then ld_load=1 with en_enable=1, d_dato=3 -> q=3, not 4.
- CONTADOR_PRESC_EN defined, PRESC=4: en_enable high 12 cycles from q=0 -> q=3; presc_tick high on cycles 4, 8 and 12. ld_load mid-sequence restarts the 4-cycle period.
